testeio_dp_ram_coherent: RTL and testbench

//  Parametrised single-clock true dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2).

---
 rtl/testeio_dp_ram_coherent.sv | 229 ++++++++++++++++++++++
 tb/tb_testeio_dp_ram_coherent.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/testeio_dp_ram_coherent.sv
// ---------------------------------------------------------------------------
// testeio_dp_ram_coherent
//
// Single-clock true dual-port RAM with two Avalon-MM slave ports (s1 =
// unsuffixed signals, s2 = signals ending in "2"). It serves as a shared
// buffer between the host CPU (s1) and a second bus master (s2).
//
// Read behaviour: a read accepted in cycle N returns the word as it is *after*
// every write of cycle N, from either port. The value is merged per byte lane.
// The result appears READ_LATENCY (1 or 2) cycles later together with a
// one-cycle readdatavalid pulse.
//
// Same-address dual write: port 1 owns the lanes it enables. Port 2 fills only
// the lanes that port 1 leaves untouched. Each such cycle is counted in a
// saturating collision counter.
//
// Ports (per slave port; port 2 uses the same names with a "2" suffix):
//   clk               in   rising-edge clock shared by both ports
//   reset             in   asynchronous, active-high
//   address           in   [ADDR_WIDTH]  word address
//   byteenable        in   [DATA_WIDTH/8] per-byte write enables
//   chipselect        in   qualifies read/write
//   read / write      in   requests (both may be set in one cycle)
//   writedata         in   [DATA_WIDTH]
//   clken             in   port clock enable
//   reset_req         in   port freeze request, treated as clken low
//   readdata          out  [DATA_WIDTH] valid while readdatavalid is high
//   readdatavalid     out  one pulse per accepted read
//   collision_count   out  [CNT_WIDTH] saturating same-address write count
//   collision_clear   in   synchronous clear; wins over an increment
// ---------------------------------------------------------------------------
module testeio_dp_ram_coherent #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  // port 1
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  input  logic                      reset_req,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  // port 2
  input  logic [ADDR_WIDTH-1:0]     address2,
  input  logic [DATA_WIDTH/8-1:0]   byteenable2,
  input  logic                      chipselect2,
  input  logic                      read2,
  input  logic                      write2,
  input  logic [DATA_WIDTH-1:0]     writedata2,
  input  logic                      clken2,
  input  logic                      reset_req2,
  output logic [DATA_WIDTH-1:0]     readdata2,
  output logic                      readdatavalid2,
  // collision statistics
  output logic [CNT_WIDTH-1:0]      collision_count,
  input  logic                      collision_clear
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("testeio_dp_ram_coherent: DATA_WIDTH must be a multiple of 8");
  end

  // Overlay the enabled byte lanes of wdata onto base.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [BE_WIDTH-1:0]   lanes
  );
    logic [DATA_WIDTH-1:0] result;
    result = base;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (lanes[i]) result[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return result;
  endfunction

  // -------------------------------------------------------------------------
  // Request qualification
  // -------------------------------------------------------------------------
  logic w_en1, w_en2;
  logic w_rd1, w_rd2;
  logic w_wr1, w_wr2;
  logic w_same_addr;
  logic w_collision;

  assign w_en1       = clken  & ~reset_req;
  assign w_en2       = clken2 & ~reset_req2;
  assign w_rd1       = w_en1 & chipselect  & read;
  assign w_rd2       = w_en2 & chipselect2 & read2;
  assign w_wr1       = w_en1 & chipselect  & write;
  assign w_wr2       = w_en2 & chipselect2 & write2;
  assign w_same_addr = (address == address2);
  assign w_collision = w_wr1 & w_wr2 & w_same_addr;

  // Effective lane enables. On a shared address, port 2 loses every lane that
  // port 1 writes. The two ports therefore never drive the same byte in the
  // same cycle, and the memory needs no write-priority logic.
  logic [BE_WIDTH-1:0] w_we1, w_we2;

  assign w_we1 = w_wr1 ? byteenable : '0;
  assign w_we2 = (w_wr2 ? byteenable2 : '0) & ~(w_same_addr ? w_we1 : '0);

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // NOTE: memory arrays get no reset branch. Clearing 2**ADDR_WIDTH words
  // cannot map onto RAM blocks, and the contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (w_we1[i]) r_mem[address][i*8 +: 8]  <= writedata[i*8 +: 8];
      if (w_we2[i]) r_mem[address2][i*8 +: 8] <= writedata2[i*8 +: 8];
    end
  end

  // -------------------------------------------------------------------------
  // New-data read path. The read takes the stored word and overlays the lanes
  // that this cycle's writes update at the same address. The lane masks are
  // disjoint, so the order of the two merges does not matter.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_fwd1, w_fwd2;

  assign w_fwd1 = merge_lanes(merge_lanes(r_mem[address], writedata2,
                                          w_same_addr ? w_we2 : '0),
                              writedata, w_we1);
  assign w_fwd2 = merge_lanes(merge_lanes(r_mem[address2], writedata,
                                          w_same_addr ? w_we1 : '0),
                              writedata2, w_we2);

  // -------------------------------------------------------------------------
  // First read stage (latency 1). A disabled port freezes its stage, so a
  // pending valid is held rather than retired or re-pulsed.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_dat1_p1, r_dat1_p2;
  logic                  r_vld1_p1, r_vld1_p2;

  // NOTE: every clocked state element below uses non-blocking assignment.
  // Each register therefore samples the pre-edge value of every other
  // register, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld1_p1 <= 1'b0;
      r_dat1_p1 <= '0;
    end else if (w_en1) begin
      r_vld1_p1 <= w_rd1;
      if (w_rd1) r_dat1_p1 <= w_fwd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld1_p2 <= 1'b0;
      r_dat1_p2 <= '0;
    end else if (w_en2) begin
      r_vld1_p2 <= w_rd2;
      if (w_rd2) r_dat1_p2 <= w_fwd2;
    end
  end

  // -------------------------------------------------------------------------
  // Optional second output stage (latency 2), frozen by the same port enable.
  // -------------------------------------------------------------------------
  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_dat2_p1, r_dat2_p2;
    logic                  r_vld2_p1, r_vld2_p2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vld2_p1 <= 1'b0;
        r_dat2_p1 <= '0;
      end else if (w_en1) begin
        r_vld2_p1 <= r_vld1_p1;
        r_dat2_p1 <= r_dat1_p1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_vld2_p2 <= 1'b0;
        r_dat2_p2 <= '0;
      end else if (w_en2) begin
        r_vld2_p2 <= r_vld1_p2;
        r_dat2_p2 <= r_dat1_p2;
      end
    end

    assign readdata       = r_dat2_p1;
    assign readdatavalid  = r_vld2_p1;
    assign readdata2      = r_dat2_p2;
    assign readdatavalid2 = r_vld2_p2;
  end else if (READ_LATENCY == 1) begin : g_lat1
    assign readdata       = r_dat1_p1;
    assign readdatavalid  = r_vld1_p1;
    assign readdata2      = r_dat1_p2;
    assign readdatavalid2 = r_vld1_p2;
  end else begin : g_bad_latency
    $error("testeio_dp_ram_coherent: READ_LATENCY must be 1 or 2");
  end

  // -------------------------------------------------------------------------
  // Collision counter: saturating; a clear overrides a same-cycle increment.
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] r_coll_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coll_cnt <= '0;
    end else if (collision_clear) begin
      r_coll_cnt <= '0;
    end else if (w_collision && !(&r_coll_cnt)) begin
      r_coll_cnt <= r_coll_cnt + CNT_WIDTH'(1);
    end
  end

  assign collision_count = r_coll_cnt;

endmodule

// File: tb/tb_testeio_dp_ram_coherent.sv
// ---------------------------------------------------------------------------
// Bench for testeio_dp_ram_coherent. Two instances share all inputs:
//   dut_a : READ_LATENCY=1, CNT_WIDTH=16
//   dut_b : READ_LATENCY=2, CNT_WIDTH=3 (counter saturates quickly)
// A word-level model applies each cycle's writes (port 1 lanes on top of
// port 2 lanes), then answers reads from the updated memory. Directed
// scenarios add literal checks at the points of interest.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_testeio_dp_ram_coherent;

  localparam int DW = 32;
  localparam int AW = 15;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] address, address2;
  logic [BW-1:0] byteenable, byteenable2;
  logic          chipselect, chipselect2, read, read2, write, write2;
  logic [DW-1:0] writedata, writedata2;
  logic          clken, clken2, reset_req, reset_req2, collision_clear;

  logic [DW-1:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic          a_rvld1, a_rvld2, b_rvld1, b_rvld2;
  logic [15:0]   a_cnt;
  logic [2:0]    b_cnt;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  testeio_dp_ram_coherent #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .clken(clken), .reset_req(reset_req),
    .readdata(a_rdata1), .readdatavalid(a_rvld1),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .read2(read2),
    .write2(write2), .writedata2(writedata2), .clken2(clken2), .reset_req2(reset_req2),
    .readdata2(a_rdata2), .readdatavalid2(a_rvld2),
    .collision_count(a_cnt), .collision_clear(collision_clear)
  );

  testeio_dp_ram_coherent #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .read(read),
    .write(write), .writedata(writedata), .clken(clken), .reset_req(reset_req),
    .readdata(b_rdata1), .readdatavalid(b_rvld1),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2), .read2(read2),
    .write2(write2), .writedata2(writedata2), .clken2(clken2), .reset_req2(reset_req2),
    .readdata2(b_rdata2), .readdatavalid2(b_rvld2),
    .collision_count(b_cnt), .collision_clear(collision_clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  logic [31:0] m_mem [int];
  logic [31:0] e_dat1 [2];   // what a latency-1 port shows
  logic        e_vld1 [2];
  logic [31:0] e_dat2 [2];   // what a latency-2 port shows
  logic        e_vld2 [2];
  int          e_cnt_a, e_cnt_b;

  function automatic logic [31:0] mem_rd(input int a);
    if (m_mem.exists(a)) return m_mem[a];
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        e_dat1[p] = '0; e_vld1[p] = 1'b0;
        e_dat2[p] = '0; e_vld2[p] = 1'b0;
      end
      e_cnt_a = 0;
      e_cnt_b = 0;
    end else begin
      bit          en [2];
      bit          rd [2];
      bit          wr [2];
      int          ad [2];
      logic [3:0]  be [2];
      logic [31:0] wd [2];
      en[0] = clken  && !reset_req;
      en[1] = clken2 && !reset_req2;
      rd[0] = en[0] && chipselect  && read;
      rd[1] = en[1] && chipselect2 && read2;
      wr[0] = en[0] && chipselect  && write;
      wr[1] = en[1] && chipselect2 && write2;
      ad[0] = int'(address);   ad[1] = int'(address2);
      be[0] = byteenable;      be[1] = byteenable2;
      wd[0] = writedata;       wd[1] = writedata2;
      // port 2 first, then port 1 over it: port 1 owns its lanes on a clash
      for (int p = 1; p >= 0; p--) begin
        if (wr[p]) begin
          logic [31:0] w;
          w = mem_rd(ad[p]);
          for (int i = 0; i < 4; i++) if (be[p][i]) w[i*8 +: 8] = wd[p][i*8 +: 8];
          m_mem[ad[p]] = w;
        end
      end
      if (collision_clear) begin
        e_cnt_a = 0;
        e_cnt_b = 0;
      end else if (wr[0] && wr[1] && ad[0] == ad[1]) begin
        e_cnt_a = (e_cnt_a == 65535) ? 65535 : e_cnt_a + 1;
        e_cnt_b = (e_cnt_b == 7)     ? 7     : e_cnt_b + 1;
      end
      // reads see the memory after this cycle's writes; a disabled port holds
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          e_vld2[p] = e_vld1[p];
          e_dat2[p] = e_dat1[p];
          e_vld1[p] = rd[p];
          if (rd[p]) e_dat1[p] = mem_rd(ad[p]);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Cycle-by-cycle comparison, away from the active edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("a_rvld1", 32'(a_rvld1), 32'(e_vld1[0]));
      check("a_rvld2", 32'(a_rvld2), 32'(e_vld1[1]));
      check("b_rvld1", 32'(b_rvld1), 32'(e_vld2[0]));
      check("b_rvld2", 32'(b_rvld2), 32'(e_vld2[1]));
      if (e_vld1[0]) check("a_rdata1", a_rdata1, e_dat1[0]);
      if (e_vld1[1]) check("a_rdata2", a_rdata2, e_dat1[1]);
      if (e_vld2[0]) check("b_rdata1", b_rdata1, e_dat2[0]);
      if (e_vld2[1]) check("b_rdata2", b_rdata2, e_dat2[1]);
      check("a_cnt", 32'(a_cnt), 32'(e_cnt_a));
      check("b_cnt", 32'(b_cnt), 32'(e_cnt_b));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // -------------------------------------------------------------------------
  task automatic idle();
    address = '0; byteenable = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; clken = 1'b1; reset_req = 1'b0;
    address2 = '0; byteenable2 = '0; chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
    writedata2 = '0; clken2 = 1'b1; reset_req2 = 1'b0;
    collision_clear = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_p1(input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = AW'(a); writedata = d; byteenable = be;
  endtask

  task automatic wr_p2(input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(a); writedata2 = d; byteenable2 = be;
  endtask

  task automatic rd_p1(input int a);
    chipselect = 1'b1; read = 1'b1; address = AW'(a);
  endtask

  task automatic rd_p2(input int a);
    chipselect2 = 1'b1; read2 = 1'b1; address2 = AW'(a);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_a_rvld1", 32'(a_rvld1), 32'h0);
    check("rst_a_rvld2", 32'(a_rvld2), 32'h0);
    check("rst_a_rdata1", a_rdata1, 32'h0);
    check("rst_b_rdata2", b_rdata2, 32'h0);
    check("rst_a_cnt", 32'(a_cnt), 32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // preload words that are read later
    for (int i = 0; i < 4; i++) begin
      idle(); wr_p1(i, 32'h1000_0000 + i, 4'hF); cyc();
    end
    idle(); wr_p2(7, 32'h0, 4'hF); cyc();

    // write on s1, read back on s2 the next cycle
    idle(); wr_p1(16, 32'hDEAD_BEEF, 4'hF); cyc();
    idle(); rd_p2(16); cyc();
    check("t1_a_rvld2", 32'(a_rvld2), 32'h1);
    check("t1_a_rdata2", a_rdata2, 32'hDEAD_BEEF);
    check("t1_b_rvld2_early", 32'(b_rvld2), 32'h0);
    idle(); cyc();
    check("t1_a_rvld2_pulse", 32'(a_rvld2), 32'h0);
    check("t1_b_rvld2", 32'(b_rvld2), 32'h1);
    check("t1_b_rdata2", b_rdata2, 32'hDEAD_BEEF);

    // same-address dual write
    idle(); wr_p1(5, 32'h1122_3344, 4'b0011); wr_p2(5, 32'hAABB_CCDD, 4'b1111); cyc();
    check("t2_a_cnt", 32'(a_cnt), 32'h1);
    check("t2_b_cnt", 32'(b_cnt), 32'h1);
    idle(); rd_p1(5); cyc();
    check("t2_a_rdata1", a_rdata1, 32'hAABB_3344);

    // read on s2 during a partial s1 write to the same word
    idle(); wr_p1(7, 32'hCAFE_F00D, 4'b1100); rd_p2(7); cyc();
    check("t3_a_rdata2", a_rdata2, 32'hCAFE_0000);

    // back-to-back reads, latency 2
    for (int i = 0; i < 4; i++) begin
      idle(); rd_p1(i); cyc();
      if (i == 0) begin
        check("t4_b_rvld1_first", 32'(b_rvld1), 32'h0);
      end else begin
        check("t4_b_rvld1", 32'(b_rvld1), 32'h1);
        check("t4_b_rdata1", b_rdata1, 32'h1000_0000 + 32'(i - 1));
      end
    end
    idle(); cyc();
    check("t4_b_rvld1_last", 32'(b_rvld1), 32'h1);
    check("t4_b_rdata1_last", b_rdata1, 32'h1000_0003);
    idle(); cyc();
    check("t4_b_rvld1_done", 32'(b_rvld1), 32'h0);

    // byteenable=0 write, then clken hold and reset_req freeze
    idle(); wr_p1(16, 32'h0, 4'h0); cyc();
    idle(); rd_p1(16); cyc();
    check("t5_a_rdata1", a_rdata1, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      idle(); clken = 1'b0; rd_p1(5); cyc();
      check("t5_hold_rvld1", 32'(a_rvld1), 32'h1);
      check("t5_hold_rdata1", a_rdata1, 32'hDEAD_BEEF);
    end
    idle(); reset_req = 1'b1; wr_p1(16, 32'h0BAD_F00D, 4'hF); rd_p1(5); cyc();
    check("t5_freeze_rvld1", 32'(a_rvld1), 32'h1);
    idle(); rd_p1(16); cyc();
    check("t5_after_freeze", a_rdata1, 32'hDEAD_BEEF);

    // collision counter: clear priority, saturation, no-clash dual write
    idle(); wr_p1(256, 32'h1, 4'hF); wr_p2(256, 32'h2, 4'hF); collision_clear = 1'b1; cyc();
    check("cnt_clear_prio", 32'(a_cnt), 32'h0);
    for (int k = 0; k < 9; k++) begin
      idle(); wr_p1(256, 32'(k), 4'hF); wr_p2(256, ~32'(k), 4'h0); cyc();
    end
    check("cnt_a_nine", 32'(a_cnt), 32'd9);
    check("cnt_b_sat", 32'(b_cnt), 32'd7);
    idle(); collision_clear = 1'b1; cyc();
    check("cnt_clear", 32'(a_cnt), 32'h0);
    idle(); wr_p1(300, 32'h1, 4'hF); wr_p2(300, 32'h2, 4'hF); cyc();
    idle(); wr_p1(301, 32'h3, 4'hF); wr_p2(302, 32'h4, 4'hF); cyc();
    check("cnt_diff_addr", 32'(a_cnt), 32'h1);

    // reset with reads in flight
    idle(); rd_p1(2); rd_p2(3);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_a_rvld1", 32'(a_rvld1), 32'h0);
    check("t6_a_rvld2", 32'(a_rvld2), 32'h0);
    check("t6_b_rvld1", 32'(b_rvld1), 32'h0);
    check("t6_b_rvld2", 32'(b_rvld2), 32'h0);
    check("t6_a_rdata1", a_rdata1, 32'h0);
    check("t6_b_rdata2", b_rdata2, 32'h0);
    check("t6_a_cnt", 32'(a_cnt), 32'h0);
    check("t6_b_cnt", 32'(b_cnt), 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 1'b0;
    idle(); rd_p2(16); cyc();
    check("t6_mem_kept_16", a_rdata2, 32'hDEAD_BEEF);
    idle(); rd_p1(7); cyc();
    check("t6_mem_kept_7", a_rdata1, 32'hCAFE_0000);
    idle(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
